// File: rtl/call_stack_pkg.sv
// call_stack_pkg: shared sizing constants for the hardware return-address stack.
//   CALL_STACK_DEPTH : default number of stack entries (power of two, >= 2)
//   ADDR_WIDTH       : CPU address width, i.e. width of one stored return PC
package call_stack_pkg;

    localparam int unsigned CALL_STACK_DEPTH = 8;
    localparam int unsigned ADDR_WIDTH       = 19;

endpackage

// File: rtl/call_stack.sv
// call_stack: hardware return-address stack fed by the control decoder.
// A CALL pushes its return PC, and a RET pops it. The top of stack is read
// combinationally, so the PC-select mux sees the target in the same cycle as the RET.
// Overflow pushes and underflow pops are dropped without touching stored entries.
//
// Optional feature: define CALL_STACK_ERR_EN to build a sticky err register.
// Without it, err is tied low.
//
// Ports:
//   clk        in   1         system clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   push       in   1         store push_addr (CALL)
//   pop        in   1         remove top entry (RET)
//   push_addr  in   ADDR_W    return address to store
//   ret_addr   out  ADDR_W    current top of stack, 0 when empty
//   count      out  PTR_W+1   number of valid entries, 0..DEPTH
//   empty      out  1         count == 0
//   full       out  1         count == DEPTH
//   err        out  1         sticky overflow/underflow flag
module call_stack
    import call_stack_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_WIDTH,
    parameter int unsigned DEPTH  = CALL_STACK_DEPTH,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    // Storage is deliberately not reset; only count defines validity.
    logic [ADDR_W-1:0] mem [0:DEPTH-1];

    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   top_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic             do_write;

    assign top_ptr = count_q - CNT_ONE;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;
    assign ret_addr = empty ? '0 : mem[top_ptr[PTR_W-1:0]];

    always_comb begin
        count_d  = count_q;
        do_write = 1'b0;
        wr_idx   = count_q[PTR_W-1:0];
        if (push && pop) begin
            // A replace overwrites the top entry in place. On an empty stack it acts as a plain push.
            do_write = 1'b1;
            if (empty) begin
                wr_idx  = '0;
                count_d = CNT_ONE;
            end else begin
                wr_idx = top_ptr[PTR_W-1:0];
            end
        end else if (push) begin
            if (!full) begin
                do_write = 1'b1;
                count_d  = count_q + CNT_ONE;
            end
        end else if (pop) begin
            if (!empty) begin
                count_d = top_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_idx] <= push_addr;
        end
    end

`ifdef CALL_STACK_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((push && !pop && full) || (pop && !push && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: table-driven directed test of call_stack, followed by hand-written
// sequences that check same-cycle read and asynchronous reset in the middle of a cycle.
module tb_call_stack;

`ifdef CALL_STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic        pop;
    logic [18:0] push_addr;
    logic [18:0] ret_addr;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        err;

    int tests = 0;
    int fails = 0;

    call_stack dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .ret_addr  (ret_addr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        bit          push;
        bit          pop;
        logic [18:0] addr;
        logic [3:0]  exp_count;
        logic [18:0] exp_ret;
        bit          exp_empty;
        bit          exp_full;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " count"}, int'(count), int'(v.exp_count));
        check({tag, " ret_addr"}, int'(ret_addr), int'(v.exp_ret));
        check({tag, " empty"}, int'(empty), int'(v.exp_empty));
        check({tag, " full"}, int'(full), int'(v.exp_full));
        check({tag, " err"}, int'(err), int'(v.exp_err));
    endtask

    // Pulse reset asynchronously between clock edges.
    task automatic pulse_rst();
        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    function automatic vec_t mk(bit r, bit pu, bit po, logic [18:0] a, logic [3:0] c,
                                logic [18:0] ra, bit e, bit f, bit er);
        vec_t v;
        v.do_rst = r; v.push = pu; v.pop = po; v.addr = a; v.exp_count = c;
        v.exp_ret = ra; v.exp_empty = e; v.exp_full = f; v.exp_err = er;
        return v;
    endfunction

    initial begin
        vec_t v;
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        check_all("reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 0));

        // Basic push/pop, then overflow.
        vecs.push_back(mk(0, 1, 0, 19'h10, 1, 19'h10, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 19'h20, 2, 19'h20, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 19'h0,  1, 19'h10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 19'h0,  0, 19'h0,  1, 0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 19'(i), 4'(i), 19'(i), 0, (i == 8), 0));
        vecs.push_back(mk(0, 1, 0, 19'h9, 8, 19'h8, 0, 1, ERR));
        vecs.push_back(mk(0, 0, 1, 19'h0, 7, 19'h7, 0, 0, ERR));
        // Underflow, with err staying sticky across a later push.
        vecs.push_back(mk(1, 0, 0, 19'h0,  0, 19'h0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 19'h0,  0, 19'h0,  1, 0, ERR));
        vecs.push_back(mk(0, 1, 0, 19'h44, 1, 19'h44, 0, 0, ERR));
        // Replace on an empty stack and on a non-empty stack.
        vecs.push_back(mk(1, 0, 0, 19'h0,  0, 19'h0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 19'h7,  1, 19'h7,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 19'h10, 2, 19'h10, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 19'h30, 3, 19'h30, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 19'h55, 3, 19'h55, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 19'h0,  2, 19'h10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 19'h0,  1, 19'h7,  0, 0, 0));

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.do_rst) begin
                pulse_rst();
                #1;
            end else begin
                push = v.push; pop = v.pop; push_addr = v.addr;
                @(posedge clk); #1;
                push = 1'b0; pop = 1'b0;
            end
            check_all($sformatf("vec%0d", i), v);
        end

        // Same-cycle read: while RET is asserted, ret_addr already shows the target.
        pulse_rst();
        push = 1'b1; push_addr = 19'h123;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b1;
        #1;
        check("ret_same_cycle", int'(ret_addr), 'h123);
        @(posedge clk); #1;
        pop = 1'b0;
        check("ret_after_pop", int'(ret_addr), 0);

        // Asynchronous reset arriving mid-cycle while push is high.
        for (int i = 1; i <= 5; i++) begin
            push = 1'b1; push_addr = 19'(i * 16);
            @(posedge clk); #1;
        end
        push = 1'b0;
        check("pre_rst_count", int'(count), 5);
        push = 1'b1; push_addr = 19'h66;
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_empty", int'(empty), 1);
        @(posedge clk); #1;
        check("rst_held_count", int'(count), 0);
        push = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ret", int'(ret_addr), 0);
        check("post_rst_count", int'(count), 0);
        check("post_rst_err", int'(err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
